// File: rtl/console_uart_mux_pkg.sv
// console_uart_mux_pkg: state encodings, channel bits and defaults shared by the console/hexbus UART mux
package console_uart_mux_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HB = 2'd1, CONS = 2'd2} state_t;
  localparam logic CH_CONS = 1'b0;
  localparam logic CH_HB = 1'b1;
  localparam logic [6:0] HB_EOP_DEF = 7'h0a;
  localparam int LGTIMEOUT_DEF = 5;
endpackage

// File: rtl/console_uart_mux_if.sv
// console_uart_mux_if: UART RX/TX byte streams plus console and hexbus char handshakes
//   slave  = mux side (takes rx/source chars, drives demuxed chars, busy flags and tx byte)
//   master = environment side (UART, console and hexbus blocks)
interface console_uart_mux_if;
  logic       i_rx_stb;
  logic [7:0] i_rx_data;
  logic       o_cons_stb;
  logic [6:0] o_cons_data;
  logic       o_hb_stb;
  logic [6:0] o_hb_data;
  logic       i_cons_stb;
  logic [6:0] i_cons_data;
  logic       o_cons_busy;
  logic       i_hb_stb;
  logic [6:0] i_hb_data;
  logic       o_hb_busy;
  logic       o_tx_stb;
  logic [7:0] o_tx_data;
  logic       i_tx_busy;
  modport slave (
    input  i_rx_stb, i_rx_data, i_cons_stb, i_cons_data, i_hb_stb, i_hb_data, i_tx_busy,
    output o_cons_stb, o_cons_data, o_hb_stb, o_hb_data, o_cons_busy, o_hb_busy, o_tx_stb, o_tx_data
  );
  modport master (
    output i_rx_stb, i_rx_data, i_cons_stb, i_cons_data, i_hb_stb, i_hb_data, i_tx_busy,
    input  o_cons_stb, o_cons_data, o_hb_stb, o_hb_data, o_cons_busy, o_hb_busy, o_tx_stb, o_tx_data
  );
endinterface

// File: rtl/console_uart_mux.sv
// console_uart_mux: shares one UART byte stream between the console (bit7=0) and hexbus (bit7=1)
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : rx byte in -> console/hexbus char strobes out; console/hexbus chars in -> tx byte out
module console_uart_mux
  import console_uart_mux_pkg::*;
#(
  parameter int         LGTIMEOUT = LGTIMEOUT_DEF,
  parameter logic [6:0] HB_EOP    = HB_EOP_DEF
) (
  input logic            i_clk,
  input logic            i_rst_n,
  console_uart_mux_if.slave bus
);
  localparam logic [LGTIMEOUT-1:0] CNT_MAX = '1;
  state_t               state_q, state_d;
  logic                 prio_q, prio_d;
  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;
  logic                 cons_stb_q, hb_stb_q;
  logic [6:0]           rx_data_q;
  logic                 tx_stb_q;
  logic [7:0]           tx_data_q;
  logic                 slot_free, cons_gnt, hb_gnt, cons_acc, hb_acc;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cons_stb_q <= 1'b0;
      hb_stb_q   <= 1'b0;
    end else begin
      cons_stb_q <= bus.i_rx_stb & ~bus.i_rx_data[7];
      hb_stb_q   <= bus.i_rx_stb & bus.i_rx_data[7];
    end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) rx_data_q <= '0;
    else if (bus.i_rx_stb) rx_data_q <= bus.i_rx_data[6:0];
  assign bus.o_cons_stb  = cons_stb_q;
  assign bus.o_hb_stb    = hb_stb_q;
  assign bus.o_cons_data = rx_data_q;
  assign bus.o_hb_data   = rx_data_q;
  // the holding register can take a new byte when empty or being drained this cycle
  assign slot_free       = ~tx_stb_q | ~bus.i_tx_busy;
  assign cons_gnt        = (state_q == CONS) & slot_free;
  assign hb_gnt          = (state_q == HB) & slot_free;
  assign cons_acc        = cons_gnt & bus.i_cons_stb;
  assign hb_acc          = hb_gnt & bus.i_hb_stb;
  assign bus.o_cons_busy = ~cons_gnt;
  assign bus.o_hb_busy   = ~hb_gnt;
  assign bus.o_tx_stb    = tx_stb_q;
  assign bus.o_tx_data   = tx_data_q;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) tx_stb_q <= 1'b0;
    else if (cons_acc | hb_acc) tx_stb_q <= 1'b1;
    else if (!bus.i_tx_busy) tx_stb_q <= 1'b0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) tx_data_q <= '0;
    else if (cons_acc) tx_data_q <= {CH_CONS, bus.i_cons_data};
    else if (hb_acc) tx_data_q <= {CH_HB, bus.i_hb_data};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= IDLE;
      prio_q  <= CH_HB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
    end
  // a hexbus grant lasts until end-of-packet or until the source idles for 2^LGTIMEOUT-1 cycles
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (bus.i_hb_stb & (~bus.i_cons_stb | prio_q == CH_HB)) state_d = HB;
        else if (bus.i_cons_stb) state_d = CONS;
      CONS:
        if (cons_acc) begin
          state_d = IDLE;
          prio_d  = CH_HB;
        end
      HB:
        if (hb_acc) begin
          cnt_d = '0;
          if (bus.i_hb_data == HB_EOP) begin
            state_d = IDLE;
            prio_d  = CH_CONS;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          prio_d  = CH_CONS;
          cnt_d   = '0;
        end else if (!bus.i_hb_stb) cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_console_uart_mux.sv
// tb_console_uart_mux: scoreboard bench with directed cases and randomized packet/char rounds
module tb_console_uart_mux;
  typedef struct {int c; logic [6:0] d;} rx_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, total = 0, bad = 0;
  int hb_last = 0;
  bit prio_hb = 1'b1;
  bit stop = 1'b0;
  rx_t cons_q[$], hb_q[$];
  logic [7:0] tx_q[$];
  logic [6:0] pkt[$];
  console_uart_mux_if bus();
  console_uart_mux #(.LGTIMEOUT(5), .HB_EOP(7'h0a)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  task automatic fail(input string n, input logic [31:0] a);
    total++;
    bad++;
    $display("FAIL %s: unexpected %0h", n, a);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.o_cons_stb) begin
      if (cons_q.size() == 0) fail("cons_extra", bus.o_cons_data);
      else begin
        chk("cons_data", bus.o_cons_data, cons_q[0].d);
        chk("cons_lat", cyc, cons_q[0].c);
        void'(cons_q.pop_front());
      end
    end
    if (bus.o_hb_stb) begin
      if (hb_q.size() == 0) fail("hb_extra", bus.o_hb_data);
      else begin
        chk("hb_data", bus.o_hb_data, hb_q[0].d);
        chk("hb_lat", cyc, hb_q[0].c);
        void'(hb_q.pop_front());
      end
    end
    if (bus.o_tx_stb && !bus.i_tx_busy) begin
      if (tx_q.size() == 0) fail("tx_extra", bus.o_tx_data);
      else chk("tx_byte", bus.o_tx_data, tx_q.pop_front());
    end
  end
  task automatic rx_put(input logic [7:0] b);
    bus.i_rx_stb = 1'b1;
    bus.i_rx_data = b;
    if (b[7]) hb_q.push_back(rx_t'{cyc + 1, b[6:0]});
    else cons_q.push_back(rx_t'{cyc + 1, b[6:0]});
    @(posedge clk);
    #1 bus.i_rx_stb = 1'b0;
  endtask
  task automatic cons_put(input logic [6:0] c, output int acc);
    int n = 0;
    bus.i_cons_stb = 1'b1;
    bus.i_cons_data = c;
    while (1) begin
      @(negedge clk);
      if (!bus.o_cons_busy) break;
      if (++n > 300) break;
    end
    if (n > 300) begin
      fail("cons_timeout", n);
      acc = -1;
    end else acc = cyc + 1;
    @(posedge clk);
    #1 bus.i_cons_stb = 1'b0;
  endtask
  task automatic hb_put(input logic [6:0] c, output int acc);
    int n = 0;
    bus.i_hb_stb = 1'b1;
    bus.i_hb_data = c;
    while (1) begin
      @(negedge clk);
      if (!bus.o_hb_busy) break;
      if (++n > 300) break;
    end
    if (n > 300) begin
      fail("hb_timeout", n);
      acc = -1;
    end else acc = cyc + 1;
    @(posedge clk);
    #1 bus.i_hb_stb = 1'b0;
  endtask
  task automatic hb_drive();
    int a;
    foreach (pkt[i]) begin
      if (i > 0) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      hb_put(pkt[i], a);
      hb_last = a;
    end
  endtask
  task automatic push_pkt();
    foreach (pkt[i]) tx_q.push_back({1'b1, pkt[i]});
  endtask
  task automatic check_idle_outputs(input string n);
    chk({n, "_tx_stb"}, bus.o_tx_stb, 0);
    chk({n, "_tx_data"}, bus.o_tx_data, 0);
    chk({n, "_cons_stb"}, bus.o_cons_stb, 0);
    chk({n, "_hb_stb"}, bus.o_hb_stb, 0);
    chk({n, "_cons_data"}, bus.o_cons_data, 0);
    chk({n, "_hb_data"}, bus.o_hb_data, 0);
    chk({n, "_cons_busy"}, bus.o_cons_busy, 1);
    chk({n, "_hb_busy"}, bus.o_hb_busy, 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
  initial begin
    int a, h, t0, r, len;
    logic [6:0] c;
    bus.i_rx_stb = 0; bus.i_rx_data = 0; bus.i_cons_stb = 0; bus.i_cons_data = 0;
    bus.i_hb_stb = 0; bus.i_hb_data = 0; bus.i_tx_busy = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    chk("idle_cons_busy", bus.o_cons_busy, 1);
    chk("idle_hb_busy", bus.o_hb_busy, 1);
    @(posedge clk);
    #1;
    rx_put(8'h41);
    rx_put(8'hC1);
    repeat (2) begin @(posedge clk); #1; end
    tx_q.push_back(8'h41);
    t0 = cyc;
    cons_put(7'h41, a);
    chk("cons_grant_lat", a - t0, 2);
    repeat (2) begin @(posedge clk); #1; end
    tx_q.push_back(8'hD2); tx_q.push_back(8'hB1); tx_q.push_back(8'h8A); tx_q.push_back(8'h41);
    pkt = '{7'h52, 7'h31, 7'h0a};
    fork
      hb_drive();
      cons_put(7'h41, a);
    join
    chk("cons_after_pkt", a > hb_last, 1);
    repeat (2) begin @(posedge clk); #1; end
    tx_q.push_back(8'hD2); tx_q.push_back(8'h41);
    fork
      hb_put(7'h52, h);
      cons_put(7'h41, a);
    join
    chk("timeout_gap", a - h, 34);
    prio_hb = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          r = $urandom_range(0, 2);
          c = 7'($urandom);
          len = $urandom_range(1, 4);
          pkt.delete();
          for (int i = 0; i < len - 1; i++) begin
            logic [6:0] x;
            do x = 7'($urandom); while (x == 7'h0a);
            pkt.push_back(x);
          end
          pkt.push_back(7'h0a);
          if (r == 0) begin
            if (prio_hb) begin
              push_pkt();
              tx_q.push_back({1'b0, c});
            end else begin
              tx_q.push_back({1'b0, c});
              push_pkt();
              prio_hb = 1'b0;
            end
          end else if (r == 1) begin
            tx_q.push_back({1'b0, c});
            prio_hb = 1'b1;
          end else begin
            push_pkt();
            prio_hb = 1'b0;
          end
          fork
            if (r != 2) cons_put(c, a);
            if (r != 1) hb_drive();
          join
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          if ($urandom_range(0, 2) == 0) rx_put(8'($urandom));
          else begin @(posedge clk); #1; end
        end
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1 bus.i_tx_busy = ($urandom_range(0, 3) == 0);
        end
      end
    join
    bus.i_tx_busy = 1'b0;
    for (int i = 0; i < 50 && (tx_q.size() || cons_q.size() || hb_q.size()); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_tx", tx_q.size(), 0);
    chk("drain_rx", cons_q.size() + hb_q.size(), 0);
    tx_q.push_back(8'h5A);
    cons_put(7'h5A, a);
    bus.i_tx_busy = 1'b1;
    bus.i_hb_stb = 1'b1;
    bus.i_hb_data = 7'h11;
    repeat (10) begin
      @(negedge clk);
      chk("hold_stb", bus.o_tx_stb, 1);
      chk("hold_data", bus.o_tx_data, 8'h5A);
      chk("hold_cons_busy", bus.o_cons_busy, 1);
      chk("hold_hb_busy", bus.o_hb_busy, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    tx_q.delete();
    chk("rst_tx_stb", bus.o_tx_stb, 0);
    chk("rst_tx_data", bus.o_tx_data, 0);
    bus.i_hb_stb = 1'b0;
    bus.i_tx_busy = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rerst");
    @(posedge clk);
    #1;
    tx_q.push_back(8'h41);
    t0 = cyc;
    cons_put(7'h41, a);
    chk("rerst_grant_lat", a - t0, 2);
    repeat (4) begin @(posedge clk); #1; end
    chk("end_tx_q", tx_q.size(), 0);
    chk("end_rx_q", cons_q.size() + hb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
